// File: rtl/crc16_frame_checker.sv
// crc16_frame_checker
// Receive side of the serial CRC-16 link (poly 0x8005, init 0x0000, MSB-first, no xorout).
// Deserialises PAYLOAD_BITS payload bits followed by 16 CRC bits, runs the whole frame
// through the LFSR and reports pass (residue 0x0000) or fail on a valid/ready result port.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-low reset
//   bit_valid_i  data_i / sof_i qualify this cycle
//   data_i       serial frame bit
//   sof_i        with bit_valid_i: this bit is payload MSB of a new frame
//   busy_o       frame reception in progress
//   out_valid_o  result registers hold an unconsumed frame
//   out_ready_i  consumer accepts the result when out_valid_o && out_ready_i
//   payload_o    received payload, first received bit in the MSB
//   crc_ok_o     1 when the final residue is 0x0000
//   syndrome_o   final LFSR residue
//   overrun_o    one-cycle pulse: a new result replaced an unconsumed one
module crc16_frame_checker #(
    parameter int unsigned PAYLOAD_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bit_valid_i,
    input  logic                    data_i,
    input  logic                    sof_i,
    output logic                    busy_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [PAYLOAD_BITS-1:0] payload_o,
    output logic                    crc_ok_o,
    output logic [15:0]             syndrome_o,
    output logic                    overrun_o
);

    // One counter serves both the payload and the CRC phase.
    localparam int unsigned CNT_MAX = (PAYLOAD_BITS > 16) ? PAYLOAD_BITS : 16;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_BITS);
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(16);

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StCrc
    } state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] lfsr, input logic b);
        logic fb;
        fb = lfsr[15] ^ b;
        return {lfsr[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    state_e                  r_state;
    logic [15:0]             r_lfsr;
    logic [CNT_W-1:0]        r_cnt;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_out_valid;
    logic [PAYLOAD_BITS-1:0] r_payload;
    logic                    r_crc_ok;
    logic [15:0]             r_syndrome;
    logic                    r_overrun;

    state_e                  w_state_next;
    logic [15:0]             w_lfsr_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [PAYLOAD_BITS-1:0] w_shift_next;
    logic                    w_out_valid_next;
    logic [PAYLOAD_BITS-1:0] w_payload_next;
    logic                    w_crc_ok_next;
    logic [15:0]             w_syndrome_next;
    logic                    w_overrun_next;

    logic                    w_commit;
    logic [15:0]             w_step;
    logic [15:0]             w_seed;
    logic [CNT_W-1:0]        w_cnt_inc;

    always_comb begin
        w_state_next = r_state;
        w_lfsr_next  = r_lfsr;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_commit     = 1'b0;
        w_step       = lfsr_step(r_lfsr, data_i);
        w_seed       = lfsr_step(16'h0000, data_i);
        w_cnt_inc    = r_cnt + CNT_W'(1);

        if (bit_valid_i) begin
            if (sof_i) begin
                // Start of frame always wins: any frame in flight is dropped uncommitted.
                w_lfsr_next  = w_seed;
                w_shift_next = PAYLOAD_BITS'(data_i);
                if (PAYLOAD_BITS == 1) begin
                    w_state_next = StCrc;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = StPayload;
                    w_cnt_next   = CNT_W'(1);
                end
            end else begin
                case (r_state)
                    StPayload: begin
                        w_lfsr_next  = w_step;
                        w_shift_next = (r_shift << 1) | PAYLOAD_BITS'(data_i);
                        if (w_cnt_inc == PAY_LAST) begin
                            w_state_next = StCrc;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next   = w_cnt_inc;
                        end
                    end
                    StCrc: begin
                        w_lfsr_next = w_step;
                        if (w_cnt_inc == CRC_LAST) begin
                            w_state_next = StIdle;
                            w_cnt_next   = '0;
                            w_commit     = 1'b1;
                        end else begin
                            w_cnt_next   = w_cnt_inc;
                        end
                    end
                    default: begin
                        // Idle: bits outside a frame are ignored.
                    end
                endcase
            end
        end
    end

    // Result port: a commit in the handshake cycle replaces the result without an overrun.
    always_comb begin
        w_out_valid_next = r_out_valid;
        w_payload_next   = r_payload;
        w_crc_ok_next    = r_crc_ok;
        w_syndrome_next  = r_syndrome;
        w_overrun_next   = 1'b0;

        if (r_out_valid && out_ready_i) begin
            w_out_valid_next = 1'b0;
        end
        if (w_commit) begin
            w_out_valid_next = 1'b1;
            w_payload_next   = r_shift;
            w_syndrome_next  = w_step;
            w_crc_ok_next    = (w_step == 16'h0000);
            w_overrun_next   = r_out_valid && !out_ready_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_lfsr      <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_out_valid <= 1'b0;
            r_payload   <= '0;
            r_crc_ok    <= 1'b0;
            r_syndrome  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lfsr      <= w_lfsr_next;
            r_cnt       <= w_cnt_next;
            r_shift     <= w_shift_next;
            r_out_valid <= w_out_valid_next;
            r_payload   <= w_payload_next;
            r_crc_ok    <= w_crc_ok_next;
            r_syndrome  <= w_syndrome_next;
            r_overrun   <= w_overrun_next;
        end
    end

    assign busy_o      = (r_state != StIdle);
    assign out_valid_o = r_out_valid;
    assign payload_o   = r_payload;
    assign crc_ok_o    = r_crc_ok;
    assign syndrome_o  = r_syndrome;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// tb_crc16_frame_checker
// Scoreboard bench: expected results are queued when a frame is issued; one monitor per
// instance pops and compares on every result handshake. A 32-bit and a 72-bit instance
// share reset, data, sof and ready; each has its own bit_valid.
module tb_crc16_frame_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, data_i, sof_i, out_ready, bv32, bv72;

    logic        busy32, ov32, ok32, ovr32;
    logic [31:0] pay32;
    logic [15:0] syn32;
    logic        busy72, ov72, ok72, ovr72;
    logic [71:0] pay72;
    logic [15:0] syn72;

    crc16_frame_checker #(.PAYLOAD_BITS(32)) u_dut32 (
        .clk         (clk),
        .rst         (rst),
        .bit_valid_i (bv32),
        .data_i      (data_i),
        .sof_i       (sof_i),
        .busy_o      (busy32),
        .out_valid_o (ov32),
        .out_ready_i (out_ready),
        .payload_o   (pay32),
        .crc_ok_o    (ok32),
        .syndrome_o  (syn32),
        .overrun_o   (ovr32)
    );

    crc16_frame_checker #(.PAYLOAD_BITS(72)) u_dut72 (
        .clk         (clk),
        .rst         (rst),
        .bit_valid_i (bv72),
        .data_i      (data_i),
        .sof_i       (sof_i),
        .busy_o      (busy72),
        .out_valid_o (ov72),
        .out_ready_i (out_ready),
        .payload_o   (pay72),
        .crc_ok_o    (ok72),
        .syndrome_o  (syn72),
        .overrun_o   (ovr72)
    );

    typedef struct {
        logic [71:0] payload;
        logic        ok;
        logic [15:0] syn;
    } exp_t;

    exp_t q32[$];
    exp_t q72[$];

    int total = 0;
    int bad   = 0;
    int n_ovr32 = 0;
    int n_ovr72 = 0;

    function automatic void chk(input string name, input logic [71:0] act,
                                input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk(input logic [71:0] p, input logic ok, input logic [15:0] syn);
        exp_t e;
        e.payload = p;
        e.ok      = ok;
        e.syn     = syn;
        return e;
    endfunction

    // Monitors: compare on each handshake, count overrun pulses.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst) begin
            if (ovr32) n_ovr32++;
            if (ov32 && out_ready) begin
                if (q32.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon32_unexpected: got payload %0h want no result", pay32);
                end else begin
                    e = q32.pop_front();
                    chk("mon32_payload", 72'(pay32), e.payload);
                    chk("mon32_crc_ok", 72'(ok32), 72'(e.ok));
                    chk("mon32_syndrome", 72'(syn32), 72'(e.syn));
                end
            end
        end
    end

    always @(negedge clk) begin : mon72
        exp_t e;
        if (rst) begin
            if (ovr72) n_ovr72++;
            if (ov72 && out_ready) begin
                if (q72.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon72_unexpected: got payload %0h want no result", pay72);
                end else begin
                    e = q72.pop_front();
                    chk("mon72_payload", pay72, e.payload);
                    chk("mon72_crc_ok", 72'(ok72), 72'(e.ok));
                    chk("mon72_syndrome", 72'(syn72), 72'(e.syn));
                end
            end
        end
    end

    // Sends frame[nbits-1:0] MSB-first, sof on the first bit; returns 1 time unit after
    // the edge that sampled the last bit.
    task automatic send(input bit to72, input logic [87:0] frame, input int nbits,
                        input bit gaps);
        int g;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (gaps) begin
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    bv32   = 1'b0;
                    bv72   = 1'b0;
                    sof_i  = 1'b0;
                    data_i = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            data_i = frame[i];
            sof_i  = (i == nbits - 1);
            if (to72) bv72 = 1'b1;
            else      bv32 = 1'b1;
            @(posedge clk);
            #1;
        end
        bv32  = 1'b0;
        bv72  = 1'b0;
        sof_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset32(input string tag);
        chk({tag, "_busy"}, 72'(busy32), 72'(0));
        chk({tag, "_valid"}, 72'(ov32), 72'(0));
        chk({tag, "_payload"}, 72'(pay32), 72'(0));
        chk({tag, "_crc_ok"}, 72'(ok32), 72'(0));
        chk({tag, "_syndrome"}, 72'(syn32), 72'(0));
        chk({tag, "_overrun"}, 72'(ovr32), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        data_i    = 1'b0;
        sof_i     = 1'b0;
        bv32      = 1'b0;
        bv72      = 1'b0;
        out_ready = 1'b1;
        idle(2);
        chk_reset32("reset");
        chk("reset72_valid", 72'(ov72), 72'(0));
        rst = 1'b1;
        idle(1);

        // Reset with a pending result and a frame in flight drops everything.
        out_ready = 1'b0;
        send(1'b0, {40'h0, 32'h0000_0001, 16'h8005}, 48, 1'b0);
        chk("t1_pending_valid", 72'(ov32), 72'(1));
        send(1'b0, 88'h2A5, 10, 1'b0);
        chk("t1_midframe_busy", 72'(busy32), 72'(1));
        rst = 1'b0;
        idle(2);
        chk_reset32("t1_after_reset");
        rst       = 1'b1;
        out_ready = 1'b1;
        idle(1);

        // Good frame: x^16 mod P = 0x8005, so payload 1 carries CRC 0x8005.
        q32.push_back(mk(72'h1, 1'b1, 16'h0000));
        send(1'b0, {40'h0, 32'h0000_0001, 16'h8005}, 48, 1'b0);
        chk("t2_latency_valid", 72'(ov32), 72'(1));
        idle(1);
        chk("t2_valid_clears", 72'(ov32), 72'(0));
        idle(1);

        // Error e(x)=1 in the last CRC bit: the LFSR leaves e(x)*x^16 mod P = 0x8005.
        q32.push_back(mk(72'h1, 1'b0, 16'h8005));
        send(1'b0, {40'h0, 32'h0000_0001, 16'h8004}, 48, 1'b0);
        idle(2);

        // Restart on sof at payload bit 10: only the second frame is reported.
        send(1'b0, 88'h2A5, 10, 1'b0);
        q32.push_back(mk(72'h0, 1'b1, 16'h0000));
        send(1'b0, 88'h0, 48, 1'b0);
        idle(2);

        // Back-to-back frames while the consumer stalls.
        out_ready = 1'b0;
        send(1'b0, {40'h0, 32'h0000_0001, 16'h8005}, 48, 1'b0);
        q32.push_back(mk(72'h0, 1'b0, 16'h8005));
        send(1'b0, {40'h0, 32'h0000_0000, 16'h0001}, 48, 1'b0);
        chk("t6_overrun_pulse", 72'(ovr32), 72'(1));
        chk("t6_valid_held", 72'(ov32), 72'(1));
        chk("t6_second_payload", 72'(pay32), 72'(0));
        chk("t6_second_syndrome", 72'(syn32), 72'(16'h8005));
        idle(1);
        chk("t6_overrun_one_cycle", 72'(ovr32), 72'(0));
        chk("t6_valid_still_held", 72'(ov32), 72'(1));
        out_ready = 1'b1;
        idle(1);
        chk("t6_handshake_clears", 72'(ov32), 72'(0));
        idle(1);

        // "123456789" carries CRC 0xFEE8; bits arrive with random gaps.
        q72.push_back(mk(72'h31_3233_3435_3637_3839, 1'b1, 16'h0000));
        send(1'b1, {72'h31_3233_3435_3637_3839, 16'hFEE8}, 88, 1'b1);
        chk("t4_latency_valid", 72'(ov72), 72'(1));
        idle(3);

        chk("end_q32_drained", 72'(q32.size()), 72'(0));
        chk("end_q72_drained", 72'(q72.size()), 72'(0));
        chk("end_overruns32", 72'(n_ovr32), 72'(1));
        chk("end_overruns72", 72'(n_ovr72), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
